// File: rtl/o2b_decoder.sv
// rtl/o2b_decoder.sv - streaming one-hot/multi-hot to binary index decoder
module o2b_decoder #(
  parameter int INPUT_W   = 64,
  parameter int OUTPUT_W  = 6,
  parameter int SERIALIZE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INPUT_W-1:0]  in_onehot,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTPUT_W-1:0] out_binary,
  output logic                out_last,
  output logic                out_error,
  input  logic                clear_counters,
  output logic [CNT_W-1:0]    zero_count,
  output logic [CNT_W-1:0]    multi_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state, state_n;
  logic [INPUT_W-1:0]   res, res_n;
  logic [OUTPUT_W-1:0]  bin_n;
  logic                 last_n, err_n, valid_n;
  logic [CNT_W-1:0]     zero_n, multi_n;
  logic                 accept, zero_inc, multi_inc;
  logic [INPUT_W-1:0]   load_rest, res_rest;

  function automatic logic [OUTPUT_W-1:0] low_idx(input logic [INPUT_W-1:0] v);
    low_idx = '0;
    for (int i = INPUT_W - 1; i >= 0; i--) begin
      if (v[i]) low_idx = OUTPUT_W'(i);
    end
  endfunction

  function automatic logic [INPUT_W-1:0] low_bit(input logic [INPUT_W-1:0] v);
    return v & (~v + INPUT_W'(1));
  endfunction

  // Accepting on the final beat's handshake is what gives bubble-free streaming
  assign in_ready  = !i_rst && ((state == IDLE) || (out_valid && out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign load_rest = in_onehot & ~low_bit(in_onehot);
  assign res_rest  = res & ~low_bit(res);

  always_comb begin
    state_n   = state;
    res_n     = res;
    bin_n     = out_binary;
    last_n    = out_last;
    err_n     = out_error;
    valid_n   = out_valid;
    zero_inc  = 1'b0;
    multi_inc = 1'b0;

    if (accept) begin
      if (in_onehot == '0) begin
        zero_inc = 1'b1;
        valid_n  = 1'b0;
        state_n  = IDLE;
      end else begin
        bin_n     = low_idx(in_onehot);
        err_n     = |load_rest;
        multi_inc = |load_rest;
        valid_n   = 1'b1;
        state_n   = EMIT;
        if (SERIALIZE != 0) begin
          res_n  = load_rest;
          last_n = ~|load_rest;
        end else begin
          res_n  = '0;
          last_n = 1'b1;
        end
      end
    end else if (state == EMIT && out_valid && out_ready) begin
      if (out_last) begin
        valid_n = 1'b0;
        state_n = IDLE;
      end else begin
        bin_n  = low_idx(res);
        res_n  = res_rest;
        last_n = ~|res_rest;
      end
    end

    // Clear dominates a same-cycle increment; counters stick at all-ones
    zero_n = zero_count;
    if (clear_counters) zero_n = '0;
    else if (zero_inc && zero_count != '1) zero_n = zero_count + CNT_W'(1);

    multi_n = multi_count;
    if (clear_counters) multi_n = '0;
    else if (multi_inc && multi_count != '1) multi_n = multi_count + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      res         <= '0;
      out_binary  <= '0;
      out_last    <= 1'b0;
      out_error   <= 1'b0;
      out_valid   <= 1'b0;
      zero_count  <= '0;
      multi_count <= '0;
    end else begin
      state       <= state_n;
      res         <= res_n;
      out_binary  <= bin_n;
      out_last    <= last_n;
      out_error   <= err_n;
      out_valid   <= valid_n;
      zero_count  <= zero_n;
      multi_count <= multi_n;
    end
  end

endmodule

// File: tb/tb_o2b_decoder.sv
// tb/tb_o2b_decoder.sv - scoreboard bench for o2b_decoder (serializing and single-index variants)
module tb_o2b_decoder;

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [63:0] in_onehot [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [5:0]  out_binary [2];
  logic        out_last [2];
  logic        out_error [2];
  logic        clear_counters [2];
  logic [1:0]  zc0, mc0;
  logic [15:0] zc1, mc1;

  beat_t q0[$];
  beat_t q1[$];
  int    tests = 0;
  int    fails = 0;
  int    stalls [2];
  int    mz [2];
  int    mm [2];
  bit    rdy_mode [2];
  bit    rdy_force [2];
  bit    hold_v [2];
  beat_t hold_b [2];

  always #5 clk = ~clk;

  o2b_decoder #(.INPUT_W(64), .OUTPUT_W(6), .SERIALIZE(0), .CNT_W(2)) u0 (
    .i_clk(clk), .i_rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_onehot(in_onehot[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_binary(out_binary[0]),
    .out_last(out_last[0]), .out_error(out_error[0]),
    .clear_counters(clear_counters[0]), .zero_count(zc0), .multi_count(mc0)
  );

  o2b_decoder #(.INPUT_W(64), .OUTPUT_W(6), .SERIALIZE(1), .CNT_W(16)) u1 (
    .i_clk(clk), .i_rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_onehot(in_onehot[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_binary(out_binary[1]),
    .out_last(out_last[1]), .out_error(out_error[1]),
    .clear_counters(clear_counters[1]), .zero_count(zc1), .multi_count(mc1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int zcnt(input int d);
    return (d == 1) ? int'(zc1) : int'(zc0);
  endfunction

  function automatic int mcnt(input int d);
    return (d == 1) ? int'(mc1) : int'(mc0);
  endfunction

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q0.size();
  endfunction

  // Reference: list the set bit positions, emit all (or just the first), count diagnostics
  task automatic model_accept(input int d, input logic [63:0] v, input bit clr);
    int    ids[$];
    int    n;
    int    cap;
    beat_t b;
    for (int i = 0; i < 64; i++) if (v[i]) ids.push_back(i);
    n = (d == 1) ? ids.size() : ((ids.size() > 0) ? 1 : 0);
    for (int k = 0; k < n; k++) begin
      b.idx  = 6'(ids[k]);
      b.last = (k == n - 1);
      b.err  = (ids.size() > 1);
      if (d == 1) q1.push_back(b); else q0.push_back(b);
    end
    cap = (d == 1) ? 65535 : 3;
    if (clr) begin
      mz[d] = 0;
      mm[d] = 0;
    end else if (ids.size() == 0) begin
      if (mz[d] < cap) mz[d]++;
    end else if (ids.size() > 1) begin
      if (mm[d] < cap) mm[d]++;
    end
  endtask

  task automatic send(input int d, input logic [63:0] v, input bit clr);
    bit acc = 0;
    int w = 0;
    while (!acc) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_onehot[d] = v;
      clear_counters[d] = clr;
      #2;
      acc = in_ready[d];
      @(posedge clk);
      if (!acc) begin
        stalls[d]++;
        w++;
        if (w > 3000) begin
          chk("accept_timeout", 64'd1, 64'd0);
          break;
        end
      end
    end
    #1;
    in_valid[d] = 1'b0;
    clear_counters[d] = 1'b0;
    if (acc) begin
      model_accept(d, v, clr);
      if (v != 0) chk("first_beat_latency", 64'(out_valid[d]), 64'd1);
    end
  endtask

  task automatic drain(input int d);
    int n = 0;
    while ((qsize(d) != 0 || out_valid[d]) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(n < 3000), 64'd1);
    chk("zero_count", 64'(zcnt(d)), 64'(mz[d]));
    chk("multi_count", 64'(mcnt(d)), 64'(mm[d]));
  endtask

  function automatic logic [63:0] rand_vec();
    logic [63:0] v;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = '0;
      1: v[$urandom_range(0, 63)] = 1'b1;
      2: for (int k = 0; k < 4; k++) v[$urandom_range(0, 63)] = 1'b1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        out_ready[d] = rdy_mode[d] ? rdy_force[d] : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks each handshaked beat against the scoreboard and stall stability
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          hold_v[d] = 0;
        end else begin
          if (hold_v[d]) begin
            chk("stall_valid", 64'(out_valid[d]), 64'd1);
            chk("stall_binary", 64'(out_binary[d]), 64'(hold_b[d].idx));
            chk("stall_last", 64'(out_last[d]), 64'(hold_b[d].last));
            chk("stall_error", 64'(out_error[d]), 64'(hold_b[d].err));
          end
          if (out_valid[d] && out_ready[d]) begin
            hold_v[d] = 0;
            if (qsize(d) == 0) begin
              chk("unexpected_beat", 64'(out_binary[d]), 64'hFFFF);
            end else begin
              e = (d == 1) ? q1.pop_front() : q0.pop_front();
              chk("out_binary", 64'(out_binary[d]), 64'(e.idx));
              chk("out_last", 64'(out_last[d]), 64'(e.last));
              chk("out_error", 64'(out_error[d]), 64'(e.err));
            end
          end else if (out_valid[d]) begin
            hold_v[d] = 1;
            hold_b[d] = '{idx: out_binary[d], last: out_last[d], err: out_error[d]};
          end else begin
            hold_v[d] = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; in_onehot[d] = '0; clear_counters[d] = 0; out_ready[d] = 0;
      stalls[d] = 0; mz[d] = 0; mm[d] = 0; rdy_mode[d] = 1; rdy_force[d] = 1; hold_v[d] = 0;
    end
    #1;
    chk("rst_out_valid", 64'(out_valid[1]), 64'd0);
    chk("rst_out_binary", 64'(out_binary[1]), 64'd0);
    chk("rst_out_last", 64'(out_last[1]), 64'd0);
    chk("rst_out_error", 64'(out_error[1]), 64'd0);
    chk("rst_in_ready", 64'(in_ready[1]), 64'd0);
    chk("rst_zero_count", 64'(zc1), 64'd0);
    chk("rst_multi_count", 64'(mc1), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // back-to-back one-hot vectors with downstream always ready
    stalls[1] = 0;
    send(1, 64'h1, 0);
    send(1, 64'h8000_0000_0000_0000, 0);
    send(1, 64'h10, 0);
    chk("b2b_stalls", 64'(stalls[1]), 64'd0);
    drain(1);

    // four-bit vector serializes over four beats, next vector waits for the last
    stalls[1] = 0;
    send(1, 64'h8000_0000_0000_0091, 0);
    send(1, 64'h10, 0);
    chk("multi_stalls", 64'(stalls[1]), 64'd3);
    drain(1);
    chk("multi_count_one", 64'(mc1), 64'd1);

    // empty vectors, then clear colliding with an increment
    repeat (3) send(1, 64'h0, 0);
    drain(1);
    chk("zero_count_three", 64'(zc1), 64'd3);
    send(1, 64'h0, 1);
    drain(1);
    chk("zero_count_cleared", 64'(zc1), 64'd0);

    // stalled output, then reset while the second index is presented
    rdy_force[1] = 0;
    send(1, 64'h6, 0);
    repeat (5) @(posedge clk);
    chk("stall_idx", 64'(out_binary[1]), 64'd1);
    #1 rdy_force[1] = 1;
    @(posedge clk);
    #1 rdy_force[1] = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid[1]), 64'd0);
    chk("midrst_out_binary", 64'(out_binary[1]), 64'd0);
    chk("midrst_out_last", 64'(out_last[1]), 64'd0);
    chk("midrst_out_error", 64'(out_error[1]), 64'd0);
    chk("midrst_in_ready", 64'(in_ready[1]), 64'd0);
    chk("midrst_pending", 64'(q1.size()), 64'd1);
    q1.delete();
    q0.delete();
    for (int d = 0; d < 2; d++) begin mz[d] = 0; mm[d] = 0; end
    @(negedge clk);
    rst = 1'b0;
    rdy_force[1] = 1;
    send(1, 64'h20, 0);
    drain(1);

    // randomized traffic with random backpressure
    rdy_mode[1] = 0;
    for (int n = 0; n < 250; n++) send(1, rand_vec(), ($urandom_range(0, 19) == 0));
    drain(1);

    // lowest-index-only variant with a narrow saturating counter
    send(0, 64'h8000_0000_0000_0091, 0);
    drain(0);
    for (int n = 0; n < 5; n++) send(0, 64'h3 << n, 0);
    drain(0);
    chk("multi_count_saturated", 64'(mc0), 64'd3);
    rdy_mode[0] = 0;
    for (int n = 0; n < 100; n++) send(0, rand_vec(), ($urandom_range(0, 29) == 0));
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/o2b_decoder.md
# o2b_decoder

Streaming one-hot/multi-hot to binary decoder; the inverse of the histogram binary-to-onehot encoder. Accepts a hit vector on a valid/ready input, emits the binary index of every set bit on a valid/ready output, LSB first, one index per cycle. It also keeps saturating counters of empty and multi-hot vectors. It sits between hit-flag generation and the histogram bin-update path.

## Interface
- INPUT_W, 64, width of the one-hot/multi-hot input vector
- OUTPUT_W, 6, width of the binary index; must satisfy 2^OUTPUT_W >= INPUT_W
- SERIALIZE, 1, 1 = emit every set bit; 0 = emit only the lowest set bit and flag multi-hot
- CNT_W, 16, width of the diagnostic counters

- i_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  decoder accepts a vector this cycle
- in_onehot  in  INPUT_W  hit vector
- out_valid  out  1  index valid
- out_ready  in  1  downstream accepts index
- out_binary  out  OUTPUT_W  index of the current set bit, zero-extended
- out_last  out  1  current index is the final one of its vector
- out_error  out  1  current vector had more than one bit set
- clear_counters  in  1  synchronous clear of both counters
- zero_count  out  CNT_W  number of accepted all-zero vectors
- multi_count  out  CNT_W  number of accepted multi-hot vectors

## Operation
- The decoder has two states, IDLE and EMIT. Registers: residue R[INPUT_W], out_binary, out_last, out_error, out_valid, and the two counters.
- `lowidx(V)` is the index of the lowest set bit of V. `lowbit(V)` is V with only that bit kept.
- in_ready = (state==IDLE) OR (state==EMIT AND out_valid AND out_ready AND out_last). in_ready is combinational and is 0 while i_rst is high.
- Accept = in_valid AND in_ready. On accept of V:
  - V==0: zero_count++. No output. Next state is IDLE.
  - V!=0:
    - out_binary <= lowidx(V).
    - out_error <= (V & ~lowbit(V)) != 0.
    - If SERIALIZE=1: R <= V & ~lowbit(V) and out_last <= (R==0).
    - If SERIALIZE=0: R <= 0 and out_last <= 1.
    - out_valid <= 1. Next state is EMIT.
    - multi_count++ if out_error is being set.
- EMIT, on out_valid AND out_ready:
  - If out_last and no accept: out_valid <= 0, next state IDLE.
  - If out_last and accept: load the new vector as above. This gives back-to-back operation with no bubble.
  - If not out_last:
    - out_binary <= lowidx(R), R <= R & ~lowbit(R), out_last <= ((R & ~lowbit(R))==0).
    - out_error holds for the whole vector.
- EMIT with out_ready=0: all output registers hold their values.
- Counters: saturate at 2^CNT_W-1 with no wrap. When clear_counters and an increment occur in the same cycle, clear wins and the result is 0.
- Bits of in_onehot at or above INPUT_W do not exist. Indices always satisfy out_binary < INPUT_W.

## Timing
- Reset (async assert): state=IDLE, R=0, out_valid=0, out_binary=0, out_last=0, out_error=0, zero_count=0, multi_count=0. Reset deassertion is synchronized externally.
- Latency: a vector accepted at edge N gives its first index with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput:
  - One-hot stream: 1 vector per cycle while out_ready=1.
  - k-hot vector with SERIALIZE=1: k output cycles.
  - All-zero vector: consumes 1 input cycle and produces no output.
- out_valid never drops without a handshake. out_binary, out_last and out_error are stable while out_valid=1 and out_ready=0.
- Reset mid-vector: the residue is discarded. The first cycle after release behaves as IDLE with empty outputs.

## Test plan
- Reset, then in_onehot=64'h1, then 64'h8000_0000_0000_0000, then 64'h10, back-to-back with out_ready=1 → indices 0, 63, 4, each with out_last=1 and out_error=0. in_ready stays 1 and there are no bubbles.
- SERIALIZE=1, in_onehot=64'h8000_0000_0000_0091 → indices 0, 4, 7, 63 on consecutive cycles. out_error=1 on all four, out_last=1 only on 63, and multi_count=1. in_ready=0 until the beat carrying index 63 is accepted.
- SERIALIZE=0, same vector → a single beat with index 0, out_last=1, out_error=1.
- in_onehot=0 three times → no out_valid and zero_count=3. Then assert clear_counters in the same cycle as a fourth zero vector → zero_count=0.
- Vector 64'h6, with out_ready held low for 5 cycles → out_binary=1 held stable with out_valid=1. Releasing out_ready gives index 1, then 2. Assert i_rst during the index-2 cycle → all outputs 0 asynchronously, and the next vector decodes normally.
- Set CNT_W=2 and send 5 multi-hot vectors → multi_count saturates at 3.
